// File: rtl/song_reader_if.sv
// Song reader bus: control inputs, song ROM port and note-player load port.
interface song_reader_if #(
  parameter int unsigned NOTE_W = 6,
  parameter int unsigned DUR_W  = 6,
  parameter int unsigned SONG_W = 2,
  parameter int unsigned IDX_W  = 5
) ();
  logic                    play;
  logic [SONG_W-1:0]       song;
  logic                    note_done;
  logic [SONG_W+IDX_W-1:0] rom_addr;
  logic [NOTE_W+DUR_W-1:0] rom_data;
  logic [NOTE_W-1:0]       note;
  logic [DUR_W-1:0]        duration;
  logic                    new_note;
  logic                    song_done;

  // master: the sequencer itself; slave: controls, ROM and note player around it
  modport master (
    input  play, song, note_done, rom_data,
    output rom_addr, note, duration, new_note, song_done
  );

  modport slave (
    output play, song, note_done, rom_data,
    input  rom_addr, note, duration, new_note, song_done
  );
endinterface

// File: rtl/song_reader.sv
// Note sequencer: walks a song in a synchronous ROM, strobes each note/duration
// pair to the note player, advances on note_done and flags the end of the song.
module song_reader #(
  parameter int unsigned NOTE_W = 6,
  parameter int unsigned DUR_W  = 6,
  parameter int unsigned SONG_W = 2,
  parameter int unsigned IDX_W  = 5
) (
  input  logic         clk,
  input  logic         reset,
  song_reader_if.master bus
);

  localparam int unsigned ADDR_W = SONG_W + IDX_W;
  localparam int unsigned WORD_W = NOTE_W + DUR_W;
  localparam logic [IDX_W-1:0] IDX_LAST = '1;

  typedef enum logic [2:0] {
    S_FETCH,
    S_CAPTURE,
    S_PLAYING,
    S_ADVANCE,
    S_END
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [SONG_W-1:0] song_reg;
  logic              done_pend;
  logic [ADDR_W-1:0] rom_addr;
  logic [NOTE_W-1:0] note;
  logic [DUR_W-1:0]  duration;
  logic              new_note;
  logic              song_done;

  logic [WORD_W-1:0] word;
  assign word = bus.rom_data;

  // Priority: reset, then song change, then pause, then normal sequencing.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_FETCH;
      idx       <= '0;
      song_reg  <= bus.song;
      rom_addr  <= {bus.song, IDX_W'(0)};
      done_pend <= 1'b0;
      note      <= '0;
      duration  <= '0;
      new_note  <= 1'b0;
      song_done <= 1'b0;
    end else if (bus.song != song_reg) begin
      // note/duration deliberately keep their last values until the next capture
      state     <= S_FETCH;
      idx       <= '0;
      song_reg  <= bus.song;
      rom_addr  <= {bus.song, IDX_W'(0)};
      done_pend <= 1'b0;
      new_note  <= 1'b0;
      song_done <= 1'b0;
    end else if (!bus.play) begin
      // Frozen; a note_done arriving now is remembered for when play resumes.
      new_note  <= 1'b0;
      song_done <= 1'b0;
      if (state == S_PLAYING && bus.note_done) begin
        done_pend <= 1'b1;
      end
    end else begin
      new_note  <= 1'b0;
      song_done <= 1'b0;
      case (state)
        S_FETCH: state <= S_CAPTURE;
        S_CAPTURE: begin
          if (word[DUR_W-1:0] == '0) begin
            song_done <= 1'b1;
            state     <= S_END;
          end else begin
            note     <= word[WORD_W-1:DUR_W];
            duration <= word[DUR_W-1:0];
            new_note <= 1'b1;
            state    <= S_PLAYING;
          end
        end
        S_PLAYING: begin
          if (bus.note_done || done_pend) begin
            done_pend <= 1'b0;
            state     <= S_ADVANCE;
          end
        end
        S_ADVANCE: begin
          if (idx == IDX_LAST) begin
            song_done <= 1'b1;
            state     <= S_END;
          end else begin
            idx      <= idx + IDX_W'(1);
            rom_addr <= {song_reg, idx + IDX_W'(1)};
            state    <= S_FETCH;
          end
        end
        S_END:   state <= S_END;
        default: state <= S_FETCH;
      endcase
    end
  end

  assign bus.rom_addr  = rom_addr;
  assign bus.note      = note;
  assign bus.duration  = duration;
  assign bus.new_note  = new_note;
  assign bus.song_done = song_done;

endmodule

// File: tb/tb_song_reader.sv
// Scoreboard bench for song_reader: a ROM model, directed stimulus pushing
// expected strobes, and a monitor comparing every new_note/song_done event.
module tb_song_reader;

  logic clk;
  logic reset;

  song_reader_if bus ();

  song_reader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit         is_done;
    logic [5:0] note;
    logic [5:0] dur;
  } exp_t;

  exp_t       exp_q[$];
  logic [11:0] rom [128];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int evt_count = 0;
  int last_evt_cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous ROM: data one cycle after address
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  task automatic check(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Monitor: every strobe must match the head of the expected queue
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.new_note && bus.song_done) begin
        tests++;
        fails++;
        $display("FAIL overlap: new_note and song_done both high at cycle %0d", cyc);
      end
      if (bus.new_note || bus.song_done) begin
        exp_t e;
        evt_count++;
        last_evt_cyc = cyc;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected: new_note=%0b song_done=%0b at cycle %0d, expected none",
                   bus.new_note, bus.song_done, cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.is_done) begin
            if (!bus.song_done) begin
              fails++;
              $display("FAIL event: got new_note note=%0d dur=%0d, expected song_done",
                       bus.note, bus.duration);
            end
          end else if (!bus.new_note || bus.note != e.note || bus.duration != e.dur) begin
            fails++;
            $display("FAIL event: got new_note=%0b note=%0d dur=%0d, expected note=%0d dur=%0d",
                     bus.new_note, bus.note, bus.duration, e.note, e.dur);
          end
        end
      end
    end
  end

  task automatic push_note(input logic [11:0] w);
    exp_t e;
    e.is_done = 1'b0;
    e.note    = w[11:6];
    e.dur     = w[5:0];
    exp_q.push_back(e);
  endtask

  task automatic push_done();
    exp_t e;
    e.is_done = 1'b1;
    e.note    = '0;
    e.dur     = '0;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name, input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0) return;
    end
    tests++;
    fails++;
    $display("FAIL %s: timeout, %0d expected events outstanding, expected 0", name, exp_q.size());
    exp_q.delete();
  endtask

  task automatic pulse_done(output int t0);
    @(posedge clk);
    #1;
    bus.note_done = 1'b1;
    t0 = cyc;
    @(posedge clk);
    #1;
    bus.note_done = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
  endtask

  initial begin
    int t0;
    int rel;
    int snap;

    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < 32; k++) begin
        rom[s*32+k] = {6'((s*13 + k) % 64), 6'(k + 1)};
      end
    end
    rom[32] = {6'd12, 6'd4};
    rom[33] = {6'd20, 6'd2};
    rom[34] = {6'd9,  6'd0};
    rom[96] = {6'd7,  6'd9};
    rom[97] = {6'd8,  6'd3};
    rom[98] = {6'd9,  6'd0};

    clk = 1'b0;
    reset = 1'b1;
    bus.play = 1'b1;
    bus.song = 2'd1;
    bus.note_done = 1'b0;

    // Reset state and song start latency
    wait_cycles(3);
    @(negedge clk);
    check("reset_rom_addr", int'(bus.rom_addr), 32);
    check("reset_new_note", int'(bus.new_note), 0);
    check("reset_song_done", int'(bus.song_done), 0);
    check("reset_note", int'(bus.note), 0);
    check("reset_duration", int'(bus.duration), 0);
    push_note({6'd12, 6'd4});
    @(posedge clk);
    #1;
    reset = 1'b0;
    rel = cyc;
    drain("first_note", 20);
    check("start_latency", last_evt_cyc - rel, 2);

    // No second strobe without note_done, then next note 4 cycles after note_done
    snap = evt_count;
    wait_cycles(8);
    check("hold_playing", evt_count, snap);
    push_note({6'd20, 6'd2});
    pulse_done(t0);
    drain("second_note", 20);
    check("advance_latency", last_evt_cyc - t0, 4);

    // End marker: one song_done then silence in END
    push_done();
    pulse_done(t0);
    drain("end_marker", 20);
    snap = evt_count;
    wait_cycles(50);
    check("end_silent", evt_count, snap);

    // Song 2: a full 32-note song ends via the index check
    snap = evt_count;
    push_note(rom[64]);
    @(posedge clk);
    #1;
    bus.song = 2'd2;
    drain("song2_first", 20);
    for (int k = 1; k < 32; k++) begin
      push_note(rom[64+k]);
      pulse_done(t0);
      drain("song2_note", 20);
    end
    check("song2_note_count", evt_count - snap, 32);
    push_done();
    pulse_done(t0);
    drain("song2_done", 20);
    check("song2_total", evt_count - snap, 33);
    wait_cycles(10);
    check("song2_end_silent", evt_count - snap, 33);

    // Pause in CAPTURE withholds the strobe until play returns
    @(posedge clk);
    #1;
    bus.song = 2'd3;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    bus.play = 1'b0;
    snap = evt_count;
    wait_cycles(6);
    check("pause_capture_withheld", evt_count, snap);
    push_note(rom[96]);
    @(posedge clk);
    #1;
    bus.play = 1'b1;
    t0 = cyc;
    drain("pause_capture_release", 20);
    check("pause_capture_latency", last_evt_cyc - t0, 1);
    check("pause_capture_once", evt_count - snap, 1);

    // note_done while paused in PLAYING is honoured only once play returns
    @(posedge clk);
    #1;
    bus.play = 1'b0;
    pulse_done(t0);
    snap = evt_count;
    wait_cycles(8);
    check("pause_playing_held", evt_count, snap);
    push_note(rom[97]);
    @(posedge clk);
    #1;
    bus.play = 1'b1;
    t0 = cyc;
    drain("pause_playing_release", 20);
    check("pause_playing_latency", last_evt_cyc - t0, 4);

    // Song change 3->1, run to idx 5, then change to 3 together with note_done
    rom[34] = {6'd33, 6'd5};
    push_note(rom[32]);
    @(posedge clk);
    #1;
    bus.song = 2'd1;
    drain("song1_restart", 20);
    for (int k = 1; k <= 5; k++) begin
      push_note(rom[32+k]);
      pulse_done(t0);
      drain("song1_walk", 20);
    end
    push_note(rom[96]);
    @(posedge clk);
    #1;
    bus.song = 2'd3;
    bus.note_done = 1'b1;
    @(posedge clk);
    #1;
    bus.note_done = 1'b0;
    @(negedge clk);
    check("change_rom_addr", int'(bus.rom_addr), 96);
    drain("change_first_note", 20);
    snap = evt_count;
    wait_cycles(12);
    check("change_drops_note_done", evt_count, snap);

    // Reset mid-song at idx 7 of song 2
    push_note(rom[64]);
    @(posedge clk);
    #1;
    bus.song = 2'd2;
    drain("song2b_first", 20);
    for (int k = 1; k <= 7; k++) begin
      push_note(rom[64+k]);
      pulse_done(t0);
      drain("song2b_walk", 20);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("midreset_note", int'(bus.note), 0);
    check("midreset_duration", int'(bus.duration), 0);
    check("midreset_new_note", int'(bus.new_note), 0);
    check("midreset_song_done", int'(bus.song_done), 0);
    check("midreset_rom_addr", int'(bus.rom_addr), 64);
    push_note(rom[64]);
    @(posedge clk);
    #1;
    reset = 1'b0;
    rel = cyc;
    drain("midreset_restart", 20);
    check("midreset_latency", last_evt_cyc - rel, 2);

    wait_cycles(4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
